// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU execution unit.
// ALU control codes and the FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational part of the ALU: all single-cycle operations.
// Shift codes pass b through, which is the zero-amount shift result.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       gctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the single-cycle function of a and b
    always_comb begin
        y = b;
        unique case (gctl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_NOR: y = ~(a | b);
            ALU_SLT: begin
                y    = '0;
                y[0] = $signed(a) < $signed(b);
            end
            ALU_SLL: y = b;
            ALU_SRL: y = b;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// EX-stage ALU: one-cycle logic/arith ops, bit-serial shifts.
// Shifts hold busy while iterating; done pulses on every completion.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         gctl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy,
    output logic               done
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_right;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_comb_y;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_is_shift;
    logic               w_long_shift;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .gctl (gctl),
        .a    (a),
        .b    (b),
        .y    (w_comb_y)
    );

    // Classify the request and form the next one-bit shift step
    always_comb begin
        w_is_shift   = (gctl == ALU_SLL) || (gctl == ALU_SRL);
        w_long_shift = w_is_shift && (shamt != '0);
        w_shift_next = r_right ? (r_sreg >> 1) : (r_sreg << 1);
    end

    // FSM, shift datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sreg   <= '0;
            r_cnt    <= '0;
            r_right  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_long_shift) begin
                            r_sreg  <= b;
                            r_cnt   <= shamt;
                            r_right <= (gctl == ALU_SRL);
                            r_busy  <= 1'b1;
                            r_state <= SHIFT;
                        end else begin
                            r_result <= w_comb_y;
                            r_zero   <= (w_comb_y == '0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_sreg <= w_shift_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CNT_ONE) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec.
// Random and directed ops against a behavioural reference model.
module tb_alu_seq_exec;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    gctl;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic [W-1:0]  result;
    logic          zero;
    logic          busy;
    logic          done;

    int n_pass;
    int n_tot;

    alu_seq_exec #(
        .WIDTH   (W),
        .SHAMT_W (SW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .gctl   (gctl),
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_res(
        input logic [2:0] op, input logic [W-1:0] x,
        input logic [W-1:0] y, input int sh);
        int sx;
        int sy;
        sx = x;
        sy = y;
        case (op)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b011:  return ~(x | y);
            3'b100:  return y << sh;
            3'b101:  return y >> sh;
            default: return (sx < sy) ? 1 : 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input int sh);
        if ((op == 3'b100 || op == 3'b101) && sh > 0)
            return sh + 1;
        return 1;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(
        input logic [2:0] op, input logic [W-1:0] x,
        input logic [W-1:0] y, input int sh,
        output int lat, output int bcnt);
        gctl  = op;
        a     = x;
        b     = y;
        shamt = SW'(sh);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        int bc;
        rst_n = 1'b0;
        start = 1'b0;
        gctl  = '0;
        a     = '0;
        b     = '0;
        shamt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tot++;
        if (result !== 0 || zero !== 1 || busy !== 0 || done !== 0)
            $display("FAIL reset_init r=%h z=%b b=%b d=%b want 0 1 0 0",
                     result, zero, busy, done);
        else n_pass++;
        run_op(ALU_ADD, 7, 5, 0, lat, bc);
        n_tot++;
        if (result !== 12) $display("FAIL reset_pre r=%0d want 12", result);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_tot++;
        if (result !== 0 || zero !== 1 || busy !== 0 || done !== 0)
            $display("FAIL reset_async r=%h z=%b b=%b d=%b want 0 1 0 0",
                     result, zero, busy, done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [2:0]   ops [4];
        logic [W-1:0] xs  [4];
        logic [W-1:0] ys  [4];
        logic [W-1:0] ex  [4];
        int lat;
        int bc;
        ops = '{ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT};
        xs  = '{7, 5, 0, 32'hFFFF_FFFF};
        ys  = '{5, 5, 0, 1};
        ex  = '{12, 0, 32'hFFFF_FFFF, 1};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], 0, lat, bc);
            n_tot++;
            if (lat !== 1 || result !== ex[i] || zero !== (ex[i] == 0))
                $display("FAIL single%0d lat=%0d r=%h z=%b want 1 %h %b",
                         i, lat, result, zero, ex[i], ex[i] == 0);
            else n_pass++;
            @(negedge clk);
            n_tot++;
            if (done !== 0) $display("FAIL single%0d_pulse d=%b want 0", i, done);
            else n_pass++;
        end
    endtask

    task automatic test_shift();
        int lat;
        int bc;
        run_op(ALU_SLL, 0, 1, 4, lat, bc);
        n_tot++;
        if (lat !== 5 || bc !== 4 || result !== 32'h10 || zero !== 0)
            $display("FAIL sll4 lat=%0d busy=%0d r=%h want 5 4 10", lat, bc, result);
        else n_pass++;
        @(negedge clk);
        run_op(ALU_SRL, 0, 32'h8000_0000, 31, lat, bc);
        n_tot++;
        if (lat !== 32 || bc !== 31 || result !== 1)
            $display("FAIL srl31 lat=%0d busy=%0d r=%h want 32 31 1", lat, bc, result);
        else n_pass++;
        @(negedge clk);
        run_op(ALU_SRL, 0, 1, 1, lat, bc);
        n_tot++;
        if (lat !== 2 || result !== 0 || zero !== 1)
            $display("FAIL srl_zero lat=%0d r=%h z=%b want 2 0 1", lat, result, zero);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_disturb();
        int dn;
        int dcyc;
        int held_bad;
        logic [W-1:0] r0;
        logic [W-1:0] rd;
        r0 = result;
        gctl  = ALU_SRL;
        a     = '0;
        b     = 32'hFF00;
        shamt = 8;
        start = 1'b1;
        @(negedge clk);
        dn = 0; dcyc = 0; held_bad = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                dn++;
                dcyc = i;
                rd   = result;
            end else if (dn == 0 && result !== r0) held_bad++;
            if (i >= 2 && i <= 6) begin
                start = 1'b1;
                gctl  = ALU_ADD;
                a     = $urandom;
                b     = $urandom;
                shamt = SW'($urandom);
            end else start = 1'b0;
            @(negedge clk);
        end
        n_tot++;
        if (dn !== 1 || dcyc !== 9 || rd !== 32'hFF)
            $display("FAIL disturb pulses=%0d at=%0d r=%h want 1 9 ff", dn, dcyc, rd);
        else n_pass++;
        n_tot++;
        if (held_bad !== 0) $display("FAIL disturb_hold changes=%0d want 0", held_bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        int bmax;
        bmax = 0;
        run_op(ALU_SLL, 0, 32'hABCD, 0, lat, bc);
        n_tot++;
        if (lat !== 1 || bc !== 0 || busy !== 0 || result !== 32'hABCD)
            $display("FAIL shamt0 lat=%0d busy=%0d r=%h want 1 0 abcd", lat, bc, result);
        else n_pass++;
        run_op(ALU_SLL, 0, 32'h3, 3, lat, bc);
        n_tot++;
        if (lat !== 4 || result !== 32'h18)
            $display("FAIL b2b_shift lat=%0d r=%h want 4 18", lat, result);
        else n_pass++;
        run_op(ALU_SUB, 9, 4, 0, lat, bc);
        n_tot++;
        if (lat !== 1 || result !== 5)
            $display("FAIL b2b_sub lat=%0d r=%h want 1 5", lat, result);
        else n_pass++;
        run_op(ALU_OR, 32'hF0, 32'h0F, 0, lat, bc);
        n_tot++;
        if (lat !== 1 || done !== 1 || result !== 32'hFF)
            $display("FAIL b2b_or lat=%0d d=%b r=%h want 1 1 ff", lat, done, result);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dn;
        int lat;
        int bc;
        gctl  = ALU_SLL;
        b     = 1;
        shamt = 10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tot++;
        if (busy !== 0 || result !== 0 || zero !== 1 || done !== 0)
            $display("FAIL rst_mid b=%b r=%h z=%b d=%b want 0 0 1 0",
                     busy, result, zero, done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        n_tot++;
        if (dn !== 0) $display("FAIL rst_mid_quiet activity=%0d want 0", dn);
        else n_pass++;
        run_op(ALU_ADD, 1, 1, 0, lat, bc);
        n_tot++;
        if (lat !== 1 || result !== 2 || zero !== 0)
            $display("FAIL rst_mid_add lat=%0d r=%h want 1 2", lat, result);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] ex;
        int sh;
        int lat;
        int bc;
        int el;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            x  = $urandom;
            y  = $urandom;
            if (i % 7 == 0) y = x;
            sh = (i % 3 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            ex = ref_res(op, x, y, sh);
            el = ref_lat(op, sh);
            run_op(op, x, y, sh, lat, bc);
            n_tot++;
            if (lat !== el || bc !== el - 1 || result !== ex || zero !== (ex == 0))
                $display("FAIL rand%0d op=%0d lat=%0d busy=%0d r=%h want %0d %0d %h",
                         i, op, lat, bc, result, el, el - 1, ex);
            else n_pass++;
            if (i % 2 == 0) @(negedge clk);
        end
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        test_reset();
        test_single();
        test_shift();
        test_disturb();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
